mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  32  rs1 value from register file rd1.
REQ-007 op_b  input  32  rs2 value from register file rd2.
REQ-008 rd_in  input  5  destination register index.
REQ-009 busy  output  1  high from the cycle after start is accepted through the DONE cycle.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 result  output  32  computed value.
REQ-012 rd_out  output  5  latched rd_in for the accepted op.
REQ-013 we_out  output  1  done AND (rd_out != 0); drives register-file we.

Function
REQ-014 FSM states: IDLE, CALC, DONE.
REQ-015 IDLE + start=1 at edge E0: latch funct3, op_a, op_b, rd_in; state -> CALC; iteration counter = 0.
REQ-016 CALC: one radix-2 step per cycle (shift-add multiply or restoring divide); after 32 steps, state -> DONE.
REQ-017 Fixed latency: done=1 in exactly the 33rd cycle after E0, for every op including special cases.
REQ-018 DONE: done=1, busy=1; next state IDLE.
REQ-019 start while busy=1 (CALC or DONE) is ignored; it is not queued.
REQ-020 Signed ops: convert operands to magnitudes at accept; apply the result sign in the DONE computation.
REQ-021 MUL returns product[31:0]; MULH, MULHSU, MULHU return product[63:32]. MULH treats both operands as signed; MULHSU treats op_a as signed and op_b as unsigned; MULHU treats both as unsigned.
REQ-022 DIV/REM round toward zero; the remainder takes the sign of the dividend.
REQ-023 Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result op_a.
REQ-024 Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
REQ-025 result and rd_out hold their values after DONE until the next accepted start.
REQ-026 Operand inputs may change after E0 without affecting the in-flight op.

Reset
REQ-027 rst=1 at an edge forces: state IDLE, busy 0, done 0, we_out 0, result 0x00000000, rd_out 0, counter 0.
REQ-028 rst during CALC or DONE aborts the op; no done pulse follows.
REQ-029 rst has priority over start in the same cycle.

Structure
REQ-030 Package mul_div_pkg holds the funct3 encodings, the FSM state enum, and the constants DIV0_QUOT=0xFFFFFFFF and INT_MIN=0x80000000.
REQ-031 Single module; no sub-module. Internal 64-bit accumulator, 32-bit divisor/multiplicand register, and 6-bit counter.

Verification
REQ-032 MUL: op_a=7, op_b=6, rd_in=5, start at E0 -> done at E0+33, result=42, rd_out=5, we_out=1.
REQ-033 MULH: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0x00000000. MULHU with the same operands -> result=0xFFFFFFFE.
REQ-034 DIV: op_a=0xFFFFFFF9 (-7), op_b=2 -> result=0xFFFFFFFD. REM with the same operands -> result=0xFFFFFFFF.
REQ-035 DIVU: op_a=100, op_b=0 -> result=0xFFFFFFFF. REMU with the same operands -> result=100. DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000.
REQ-036 Second start asserted at E0+10 -> ignored; exactly one done pulse, at E0+33. rd_in=0 -> done=1 with we_out=0.
REQ-037 rst at E0+15 -> busy=0 next cycle; no done within 40 cycles; a new start after reset completes correctly.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared encodings and helpers for the iterative RV32M multiply/divide unit.
package mul_div_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam int unsigned N_STEPS   = 32;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic is_div_op(input funct3_e f);
        return (f inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU});
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide
// on sign-stripped magnitudes, fixed 33-cycle latency from accept to done.
//
//  state   | meaning
//  IDLE    | waiting for start; operands latched on accept
//  CALC    | one radix-2 step per cycle, 32 steps
//  DONE    | result valid, done pulse, back to IDLE
module mul_div_unit
    import mul_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        we_out
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] dvsr_q, dvsr_d;
    funct3_e     op_q, op_d;
    logic        neg_q, neg_d;
    logic        bzero_q, bzero_d;
    logic        ovf_q, ovf_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;

    funct3_e     f3_in;
    logic        sgn_a, sgn_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] acc_step;
    logic [63:0] prod_signed;
    logic [31:0] final_val;

    assign f3_in = funct3_e'(funct3);
    assign sgn_a = op_a[31] && (f3_in inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    assign sgn_b = op_b[31] && (f3_in inside {F3_MULH, F3_DIV, F3_REM});

    // Multiply: acc = {partial_hi, multiplier}, shifted right each step.
    // Divide:   acc = {remainder, dividend/quotient}, shifted left each step.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? dvsr_q : 32'd0)};
        mul_next = {mul_sum, acc_q[31:1]};
        rem_sh   = acc_q[63:31];
        div_ge   = (rem_sh >= {1'b0, dvsr_q});
        div_diff = rem_sh[31:0] - dvsr_q;
        div_next = {(div_ge ? div_diff : rem_sh[31:0]), acc_q[30:0], div_ge};
        acc_step = is_div_op(op_q) ? div_next : mul_next;
    end

    // Sign fix-up of the final step, applied as the result is registered.
    always_comb begin
        prod_signed = neg_q ? (~acc_step + 64'd1) : acc_step;
        final_val   = '0;
        case (op_q)
            F3_MUL:                       final_val = prod_signed[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_val = prod_signed[63:32];
            F3_DIV, F3_DIVU: begin
                if (bzero_q)
                    final_val = DIV0_QUOT;
                else if (ovf_q)
                    final_val = INT_MIN;
                else
                    final_val = neg_if(neg_q, acc_step[31:0]);
            end
            default: begin
                // Divide-by-zero REM falls out naturally: remainder = |op_a|, signed back to op_a.
                if (ovf_q)
                    final_val = '0;
                else
                    final_val = neg_if(neg_q, acc_step[63:32]);
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dvsr_d   = dvsr_q;
        op_d     = op_q;
        neg_d    = neg_q;
        bzero_d  = bzero_q;
        ovf_d    = ovf_q;
        rd_d     = rd_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = f3_in;
                    acc_d   = {32'd0, neg_if(sgn_a, op_a)};
                    dvsr_d  = neg_if(sgn_b, op_b);
                    neg_d   = (f3_in == F3_REM) ? sgn_a : (sgn_a ^ sgn_b);
                    bzero_d = (op_b == 32'd0);
                    ovf_d   = (f3_in inside {F3_DIV, F3_REM}) &&
                              (op_a == INT_MIN) && (op_b == 32'hFFFF_FFFF);
                    rd_d    = rd_in;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(N_STEPS - 1)) begin
                    result_d = final_val;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dvsr_q   <= '0;
            op_q     <= F3_MUL;
            neg_q    <= 1'b0;
            bzero_q  <= 1'b0;
            ovf_q    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dvsr_q   <= dvsr_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            bzero_q  <= bzero_d;
            ovf_q    <= ovf_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign rd_out = rd_q;
    assign we_out = done && (rd_q != 5'd0);

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;

    mul_div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .we_out (we_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        int          c0;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: RV32M semantics straight from the ISA rules.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        int          ia;
        int          ib;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Drive one request; optionally pulse a second start 10 edges after accept.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res,
                         input bit dup, input bit push);
        int t;
        @(negedge clk);
        t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_wait_timeout", busy, 0);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        start  = 1'b1;
        if (push) sb_q.push_back('{res: exp_res, rd: rd, we: (rd != 0), c0: cyc});
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom);
        if (dup) begin
            repeat (9) @(posedge clk);
            #1;
            funct3 = 3'b000;
            op_a   = $urandom;
            op_b   = $urandom;
            rd_in  = 5'd3;
            start  = 1'b1;
            @(posedge clk);
            #1;
            start  = 1'b0;
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", result, e.res);
                    chk("rd_out", rd_out, e.rd);
                    chk("we_out", we_out, e.we);
                    chk("latency", cyc - e.c0, 33);
                end
            end
        end
    endtask

    task automatic stimulus();
        vec_t dir[$];
        int   seen;
        int   t;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   busy,   0);
        chk("rst_done",   done,   0);
        chk("rst_we",     we_out, 0);
        chk("rst_result", result, 0);
        chk("rst_rd",     rd_out, 0);
        rst = 1'b0;

        dir.push_back('{f: 3'd0, a: 32'd7,          b: 32'd6,          rd: 5'd5,  res: 32'd42});
        dir.push_back('{f: 3'd1, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  rd: 5'd1,  res: 32'h0000_0000});
        dir.push_back('{f: 3'd3, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  rd: 5'd2,  res: 32'hFFFF_FFFE});
        dir.push_back('{f: 3'd2, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  rd: 5'd10, res: 32'hFFFF_FFFF});
        dir.push_back('{f: 3'd4, a: 32'hFFFF_FFF9,  b: 32'd2,          rd: 5'd3,  res: 32'hFFFF_FFFD});
        dir.push_back('{f: 3'd6, a: 32'hFFFF_FFF9,  b: 32'd2,          rd: 5'd4,  res: 32'hFFFF_FFFF});
        dir.push_back('{f: 3'd5, a: 32'd100,        b: 32'd0,          rd: 5'd6,  res: 32'hFFFF_FFFF});
        dir.push_back('{f: 3'd7, a: 32'd100,        b: 32'd0,          rd: 5'd7,  res: 32'd100});
        dir.push_back('{f: 3'd4, a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  rd: 5'd8,  res: 32'h8000_0000});
        dir.push_back('{f: 3'd6, a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  rd: 5'd9,  res: 32'd0});
        dir.push_back('{f: 3'd4, a: 32'hFFFF_FFF9,  b: 32'd0,          rd: 5'd11, res: 32'hFFFF_FFFF});
        dir.push_back('{f: 3'd6, a: 32'hFFFF_FFF9,  b: 32'd0,          rd: 5'd12, res: 32'hFFFF_FFF9});
        foreach (dir[i]) issue(dir[i].f, dir[i].a, dir[i].b, dir[i].rd, dir[i].res, 1'b0, 1'b1);

        // Ignored second start, and rd=0 suppresses the write enable.
        issue(3'd0, 32'd7, 32'd6, 5'd0, 32'd42, 1'b1, 1'b1);

        // Abort mid-calculation: no done pulse may follow.
        issue(3'd5, 32'd12345, 32'd17, 5'd9, 32'd0, 1'b0, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",   busy,   0);
        chk("abort_done",   done,   0);
        chk("abort_result", result, 0);
        chk("abort_rd",     rd_out, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen += int'(done);
        end
        chk("abort_no_done", seen, 0);

        issue(3'd5, 32'd1000, 32'd7, 5'd31, 32'd142, 1'b0, 1'b1);

        for (int n = 0; n < 60; n++) begin
            f = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            issue(f, a, b, 5'($urandom), ref_model(f, a, b), 1'b0, 1'b1);
        end

        t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'd0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        rd_in  = 5'd0;
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
